sipo_deserializer: RTL and testbench

- Serial-in/parallel-out receiver. Counterpart to the 16-bit PISO transmitter.
- Samples one serial bit per CLK cycle while EN is high and assembles WIDTH bits into a word.
- Presents the word on OUT with a VALID/ACK handshake.
- Detects framing faults (mid-frame restart, EN-low timeout) and unacknowledged overwrites.

---
 rtl/sipo_deserializer.sv | 153 +++++++++++++++
 tb/tb_sipo_deserializer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// sipo_deserializer
//
// Serial-in / parallel-out receiver. One serial bit is taken per clock while
// EN is high; WIDTH bits are assembled into a word that is presented on OUT
// under a VALID/ACK handshake. Framing faults (mid-frame restart, EN-low
// timeout) discard the partial frame and pulse ERR. OVR records a word that
// was overwritten before the consumer acknowledged it.
//
// Ports:
//   CLK      clock, rising edge
//   RST      synchronous reset, active-high, highest priority
//   EN       SIN is valid this cycle
//   SIN      serial data bit
//   START    qualified by EN: SIN is bit 0 of a new frame
//   ACK      consumer accepts OUT, clears VALID
//   OUT      last complete received word
//   VALID    OUT holds an unconsumed word
//   BUSY     a frame is partially received
//   BIT_CNT  bits received so far in the current frame
//   ERR      one-cycle pulse: partial frame discarded
//   OVR      sticky: a word was overwritten before ACK

module sipo_deserializer #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1,
    parameter int TIMEOUT   = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     EN,
    input  logic                     SIN,
    input  logic                     START,
    input  logic                     ACK,
    output logic [WIDTH-1:0]         OUT,
    output logic                     VALID,
    output logic                     BUSY,
    output logic [$clog2(WIDTH)-1:0] BIT_CNT,
    output logic                     ERR,
    output logic                     OVR
);

    localparam int CW = $clog2(WIDTH);
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [IW-1:0]    idle_cnt;

    logic [WIDTH-1:0] first_word;
    logic [WIDTH-1:0] next_word;
    logic             last_bit;
    logic             timeout_hit;

    // The first bit of a frame is placed where a full sequence of shifts will
    // carry it to its final position: the LSB end when shifting left, the
    // MSB end when shifting right. next_word is the register with SIN
    // shifted in and doubles as the completed word on the final bit.
    always_comb begin
        first_word = '0;
        next_word  = '0;
        if (MSB_FIRST) begin
            first_word = {{(WIDTH-1){1'b0}}, SIN};
            next_word  = {shreg[WIDTH-2:0], SIN};
        end else begin
            first_word = {SIN, {(WIDTH-1){1'b0}}};
            next_word  = {SIN, shreg[WIDTH-1:1]};
        end
    end

    assign last_bit = (BIT_CNT == CW'(WIDTH - 1));

    // The abort fires on the edge that samples the TIMEOUT-th consecutive
    // EN-low cycle, so the counter only has to reach TIMEOUT-1 beforehand.
    assign timeout_hit = (TIMEOUT > 0) && (idle_cnt == IW'(TIMEOUT - 1));

    assign BUSY = (state == SHIFT);

    // Single state machine for framing, handshake and fault flags. A resync
    // (START in SHIFT) is checked before completion so that a START on what
    // would have been the final bit restarts the frame instead of finishing
    // it; this is also why ERR and a completion can never coincide.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            shreg    <= '0;
            idle_cnt <= '0;
            OUT      <= '0;
            VALID    <= 1'b0;
            BIT_CNT  <= '0;
            ERR      <= 1'b0;
            OVR      <= 1'b0;
        end else begin
            ERR <= 1'b0;
            if (ACK && VALID) begin
                VALID <= 1'b0;
            end

            case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    if (EN) begin
                        shreg   <= first_word;
                        BIT_CNT <= CW'(1);
                        state   <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (EN) begin
                        idle_cnt <= '0;
                        if (START) begin
                            ERR     <= 1'b1;
                            shreg   <= first_word;
                            BIT_CNT <= CW'(1);
                        end else if (last_bit) begin
                            // Completion overrides a simultaneous ACK: the
                            // old word is consumed and the new one loads.
                            OUT     <= next_word;
                            VALID   <= 1'b1;
                            if (VALID && !ACK) begin
                                OVR <= 1'b1;
                            end
                            BIT_CNT <= '0;
                            state   <= IDLE;
                        end else begin
                            shreg   <= next_word;
                            BIT_CNT <= BIT_CNT + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        ERR      <= 1'b1;
                        BIT_CNT  <= '0;
                        idle_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        // With TIMEOUT=0 this simply wraps and is never
                        // compared, which disables the abort.
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer
//
// Drives two receivers (MSB-first and LSB-first) from the same serial stream.
// A reference model keeps the received bits of the current frame in a queue
// and builds words arithmetically once WIDTH bits have arrived; completed
// words are pushed into per-receiver scoreboards that a negedge monitor pops.
// The monitor also compares the per-cycle status outputs against the model.

module tb_sipo_deserializer;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 8;
    localparam int CW      = $clog2(WIDTH);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic sin = 1'b0;
    logic start = 1'b0;
    logic ack = 1'b0;

    logic [WIDTH-1:0] out_m, out_l;
    logic             valid_m, valid_l;
    logic             busy_m, busy_l;
    logic [CW-1:0]    bit_cnt_m, bit_cnt_l;
    logic             err_m, err_l;
    logic             ovr_m, ovr_l;

    sipo_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .TIMEOUT(TIMEOUT)) dut_m (
        .CLK(clk), .RST(rst), .EN(en), .SIN(sin), .START(start), .ACK(ack),
        .OUT(out_m), .VALID(valid_m), .BUSY(busy_m), .BIT_CNT(bit_cnt_m),
        .ERR(err_m), .OVR(ovr_m)
    );

    sipo_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .TIMEOUT(TIMEOUT)) dut_l (
        .CLK(clk), .RST(rst), .EN(en), .SIN(sin), .START(start), .ACK(ack),
        .OUT(out_l), .VALID(valid_l), .BUSY(busy_l), .BIT_CNT(bit_cnt_l),
        .ERR(err_l), .OVR(ovr_l)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit               checking = 1'b0;
    bit               frame_bits[$];
    bit               in_frame = 1'b0;
    int               stall = 0;
    bit               exp_valid = 1'b0;
    bit               exp_err = 1'b0;
    bit               exp_ovr = 1'b0;
    logic [WIDTH-1:0] exp_out_m = '0;
    logic [WIDTH-1:0] exp_out_l = '0;
    logic [WIDTH-1:0] sb_m[$];
    logic [WIDTH-1:0] sb_l[$];

    int checks = 0;
    int failures = 0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance the model by one clock edge with the inputs currently applied.
    task automatic model_step();
        bit done;
        logic [WIDTH-1:0] wm, wl;
        done = 1'b0;
        if (rst) begin
            checking = 1'b1;
            frame_bits.delete();
            in_frame = 1'b0;
            stall = 0;
            exp_valid = 1'b0;
            exp_err = 1'b0;
            exp_ovr = 1'b0;
            exp_out_m = '0;
            exp_out_l = '0;
            return;
        end
        exp_err = 1'b0;
        if (en) begin
            stall = 0;
            if (in_frame && start) begin
                exp_err = 1'b1;
                frame_bits.delete();
            end
            frame_bits.push_back(sin);
            in_frame = 1'b1;
            if (frame_bits.size() == WIDTH) begin
                done = 1'b1;
                wm = '0;
                wl = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    wm = wm | (WIDTH'(frame_bits[i]) << (WIDTH - 1 - i));
                    wl = wl | (WIDTH'(frame_bits[i]) << i);
                end
                frame_bits.delete();
                in_frame = 1'b0;
            end
        end else if (in_frame) begin
            stall++;
            if (stall == TIMEOUT) begin
                exp_err = 1'b1;
                frame_bits.delete();
                in_frame = 1'b0;
                stall = 0;
            end
        end
        if (done) begin
            if (exp_valid && !ack) exp_ovr = 1'b1;
            exp_valid = 1'b1;
            exp_out_m = wm;
            exp_out_l = wl;
            sb_m.push_back(wm);
            sb_l.push_back(wl);
        end else if (ack) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic e, input logic s,
                                  input logic st, input logic a);
        rst = r;
        en = e;
        sin = s;
        start = st;
        ack = a;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Sends the first nbits of w (MSB of w first on the wire), optionally
    // with a stall inserted before bit stall_at.
    task automatic send_word(input logic [WIDTH-1:0] w, input int nbits,
                             input int stall_at, input int stall_len,
                             input bit start_first, input bit ack_last);
        for (int i = 0; i < nbits; i++) begin
            if (i == stall_at) begin
                repeat (stall_len) apply_stimulus(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0);
            end
            apply_stimulus(1'b0, 1'b1, w[WIDTH-1-i], 1'(start_first && (i == 0)),
                           1'(ack_last && (i == nbits - 1)));
        end
    endtask

    task automatic idle_ack(input int n);
        repeat (n) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: status outputs every cycle, words from the scoreboards.
    logic prev_valid_m = 1'b0;
    logic prev_valid_l = 1'b0;

    always @(negedge clk) begin
        if (checking) begin
            check_output("busy_m", 32'(busy_m), 32'(in_frame));
            check_output("busy_l", 32'(busy_l), 32'(in_frame));
            check_output("bit_cnt_m", 32'(bit_cnt_m), 32'(frame_bits.size()));
            check_output("bit_cnt_l", 32'(bit_cnt_l), 32'(frame_bits.size()));
            check_output("err_m", 32'(err_m), 32'(exp_err));
            check_output("err_l", 32'(err_l), 32'(exp_err));
            check_output("ovr_m", 32'(ovr_m), 32'(exp_ovr));
            check_output("ovr_l", 32'(ovr_l), 32'(exp_ovr));
            check_output("valid_m", 32'(valid_m), 32'(exp_valid));
            check_output("valid_l", 32'(valid_l), 32'(exp_valid));
            check_output("out_hold_m", 32'(out_m), 32'(exp_out_m));
            check_output("out_hold_l", 32'(out_l), 32'(exp_out_l));
            if (sb_m.size() > 0) begin
                check_output("word_valid_m", 32'(valid_m), 32'd1);
                check_output("word_m", 32'(out_m), 32'(sb_m.pop_front()));
            end else if (valid_m && !prev_valid_m) begin
                check_output("spurious_valid_m", 32'(valid_m), 32'd0);
            end
            if (sb_l.size() > 0) begin
                check_output("word_valid_l", 32'(valid_l), 32'd1);
                check_output("word_l", 32'(out_l), 32'(sb_l.pop_front()));
            end else if (valid_l && !prev_valid_l) begin
                check_output("spurious_valid_l", 32'(valid_l), 32'd0);
            end
        end
        prev_valid_m = valid_m;
        prev_valid_l = valid_l;
    end

    initial begin
        $display("[TB] reset and basic frame");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(16'hAFF5, 16, -1, 0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_ack(1);

        $display("[TB] all-ones and 0F0F frames");
        send_word(16'hFFFF, 16, -1, 0, 1'b0, 1'b0);
        idle_ack(1);
        send_word(16'h0F0F, 16, -1, 0, 1'b0, 1'b0);
        idle_ack(2);

        $display("[TB] short stall and timeout");
        send_word(16'h3C96, 16, 8, 3, 1'b0, 1'b0);
        idle_ack(1);
        send_word(16'h5A5A, 8, -1, 0, 1'b0, 1'b0);
        repeat (10) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] resync mid-frame");
        send_word(16'h1234, 10, -1, 0, 1'b0, 1'b0);
        send_word(16'hC3E1, 16, -1, 0, 1'b1, 1'b0);
        idle_ack(1);

        $display("[TB] overwrite without and with ack");
        send_word(16'h1111, 16, -1, 0, 1'b0, 1'b0);
        send_word(16'h8E71, 16, -1, 0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(16'h2222, 16, -1, 0, 1'b0, 1'b0);
        send_word(16'h7B3D, 16, -1, 0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_ack(1);

        $display("[TB] reset mid-frame");
        send_word(16'hFFFF, 7, -1, 0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_word(16'h9D4B, 16, -1, 0, 1'b0, 1'b0);
        idle_ack(1);

        $display("[TB] random traffic");
        repeat (600) begin
            apply_stimulus(1'($urandom_range(199) == 0),
                           1'($urandom_range(99) < 80),
                           1'($urandom),
                           1'($urandom_range(99) < 4),
                           1'($urandom_range(99) < 30));
        end
        // Long EN-low run so any open frame times out before the end.
        repeat (12) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_output("sb_drain_m", 32'(sb_m.size()), 32'd0);
        check_output("sb_drain_l", 32'(sb_l.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
